// File: rtl/registrador_varredura.sv
// Parametrised LED-matrix column scan register: hold/load/shift/auto-rotate with step and revolution pulses.
// Optional macro REGISTRADOR_VARREDURA_BIDIR_EN adds the dir port for downward shift/rotate.
module registrador_varredura #(
   parameter int unsigned      WIDTH     = 7,
   parameter int unsigned      DIV       = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] load_data,
   input  logic             d,
`ifdef REGISTRADOR_VARREDURA_BIDIR_EN
   input  logic             dir,
`endif
   output logic [WIDTH-1:0] q,
   output logic             tick,
   output logic             wrap
);

   localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned   SW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [SW-1:0] STP_LAST = SW'(WIDTH - 1);

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_LOAD  = 2'b01,
      MODE_SHIFT = 2'b10,
      MODE_ROT   = 2'b11
   } mode_t;

   mode_t            op;
   logic             down;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [SW-1:0]    stp, stp_nx;
   logic [WIDTH-1:0] q_nx, shifted, rotated;
   logic             tick_nx, wrap_nx;

   assign op = mode_t'(mode);

`ifdef REGISTRADOR_VARREDURA_BIDIR_EN
   assign down = dir;
`else
   assign down = 1'b0;
`endif

   always_comb begin
      shifted = down ? {d, q[WIDTH-1:1]}    : {q[WIDTH-2:0], d};
      rotated = down ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]};
   end

   // Only auto-rotate keeps the prescaler running; every other mode restarts it,
   // so re-entering rotation always waits a full DIV period for the first step.
   always_comb begin
      q_nx    = q;
      cnt_nx  = '0;
      stp_nx  = stp;
      tick_nx = 1'b0;
      wrap_nx = 1'b0;
      unique case (op)
         MODE_HOLD: ;
         MODE_LOAD: begin
            q_nx   = load_data;
            stp_nx = '0;
         end
         MODE_SHIFT: begin
            q_nx    = shifted;
            tick_nx = 1'b1;
            stp_nx  = '0;
         end
         MODE_ROT: begin
            if (cnt == CNT_LAST) begin
               q_nx    = rotated;
               tick_nx = 1'b1;
               if (stp == STP_LAST) begin
                  stp_nx  = '0;
                  wrap_nx = 1'b1;
               end else begin
                  stp_nx = stp + 1'b1;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q    <= RESET_VAL;
         cnt  <= '0;
         stp  <= '0;
         tick <= 1'b0;
         wrap <= 1'b0;
      end else begin
         q    <= q_nx;
         cnt  <= cnt_nx;
         stp  <= stp_nx;
         tick <= tick_nx;
         wrap <= wrap_nx;
      end
   end

endmodule

// File: doc/registrador_varredura.md
# registrador_varredura

Parametrised column scan register for the LED-matrix column driver. It is the successor to the fixed 7-bit column register: width and step rate are configurable, and it adds an auto-rotate mode with an internal prescaler. It also reports every step and every full revolution, so the row/character sequencer can advance in lockstep with the column scan.

## Interface
- WIDTH, 7, number of column bits (≥2)
- DIV, 4, clock cycles per auto-rotate step (≥1)
- RESET_VAL, 1, value loaded into q on reset (default one-hot bit 0)

- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high; dominates all other inputs
- mode  input  2  00 hold, 01 parallel load, 10 serial shift, 11 auto-rotate
- load_data  input  WIDTH  parallel load value (mode 01)
- d  input  1  serial input (mode 10)
- dir  input  1  shift/rotate direction, 0 = up, 1 = down; present only with REGISTRADOR_VARREDURA_BIDIR_EN
- q  output  WIDTH  column register contents, registered
- tick  output  1  registered pulse: q took a shift/rotate step at the last edge
- wrap  output  1  registered pulse: q completed WIDTH consecutive auto-rotate steps at the last edge

## Operation
- Internal state: q, prescaler cnt (0..DIV-1), step counter stp (0..WIDTH-1, width clog2(WIDTH), minimum 1).
- rst=1: q<=RESET_VAL, cnt<=0, stp<=0, tick<=0, wrap<=0. Mode is ignored.
- tick and wrap default to 0 on every edge unless set below.
- mode 00 (hold): q, stp unchanged; cnt<=0.
- mode 01 (load): q<=load_data; cnt<=0; stp<=0.
- mode 10 (shift, up): q[0]<=d, q[i]<=q[i-1]; MSB discarded; tick<=1; cnt<=0; stp<=0 (rotation phase lost).
- mode 11 (auto-rotate, up):
  - cnt<DIV-1: cnt<=cnt+1; q unchanged.
  - cnt==DIV-1: q[0]<=q[WIDTH-1], q[i]<=q[i-1]; cnt<=0; tick<=1.
  - On a step with stp==WIDTH-1: stp<=0, wrap<=1. Otherwise stp<=stp+1.
- Content-agnostic: rotation is performed on any pattern, not only one-hot; wrap is position-based, not value-based.

## Timing
- Load/shift latency: one edge; new q is visible the cycle after the edge where mode is sampled.
- tick and wrap are asserted in the same cycle that the stepped q is visible, for exactly one cycle per step.
- Auto-rotate: the first step occurs DIV edges after mode becomes 11, because cnt is 0 on entry. Steps then repeat every DIV cycles. With DIV=1, q rotates every clock and tick stays high.
- wrap asserts every WIDTH*DIV cycles in uninterrupted mode 11, counted from entry with stp=0.
- Leaving mode 11 and returning to it via 00: cnt restarts from 0 and stp is preserved, so wrap still marks a full revolution.
- Leaving and returning via 01 or 10: stp is cleared.
- rst mid-operation: takes effect at the next edge irrespective of cnt/stp. tick and wrap are 0 in the cycle after reset.

## Configuration
- REGISTRADOR_VARREDURA_BIDIR_EN defined:
  - dir port exists.
  - dir=1 in mode 10: q[WIDTH-1]<=d, q[i]<=q[i+1].
  - dir=1 in mode 11: q[WIDTH-1]<=q[0], q[i]<=q[i+1].
  - dir is sampled on each step edge. Changing dir does not clear stp.
- Not defined: no dir port; behaviour is identical to dir=0.

## Test plan
- Reset: rst=1 for 2 cycles, WIDTH=7 -> q=0000001, tick=0, wrap=0.
- Load/hold: mode=01 with load_data=1010101 for one cycle, then mode=00 for 5 cycles -> q=1010101 throughout, tick=0.
- Shift: from q=0000000, mode=10 with d=1,1,0 -> q=0000001, 0000011, 0000110; tick=1 on each of the three cycles.
- Auto-rotate, DIV=4, from q=0000001:
  - q changes every 4th cycle: 0000010, 0000100, …
  - After 28 cycles q=0000001 and wrap=1 for one cycle, coincident with tick.
- Reset mid-rotate: rst=1 while cnt=2, with q=0001000 -> next cycle q=0000001, tick=0. After rst is released with mode=11, the first step occurs 4 cycles later.
- BIDIR_EN, dir=1:
  - Mode 11 with DIV=1 from 0000001 -> 1000000, then 0100000.
  - Mode 10 with d=1 from 0000000 -> 1000000.
